// File: rtl/decode_pkg.sv
// Shared constants and operand-forwarding select type for the decode stage.
package decode_pkg;

  localparam int ZERO_REG_DEF = 31;
  localparam int LINK_REG_DEF = 30;

  typedef enum logic [2:0] {
    FWD_REG,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_e;

  // Youngest producer wins; the zero register overrides every bypass.
  function automatic fwd_sel_e fwd_pick(input logic is_zero, input logic ex_hit,
                                        input logic mem_hit, input logic wb_hit);
    if (is_zero) return FWD_ZERO;
    if (ex_hit)  return FWD_EX;
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/decode_regfile_stage_if.sv
// Decode-stage bus: IF/ID inputs, downstream bypass sources, and ID/EX outputs.
interface decode_regfile_stage_if #(
  parameter int DATA_W = 64,
  parameter int AW     = 5
);
  logic              dec_valid;
  logic [31:0]       dec_inst;
  logic [DATA_W-1:0] dec_pc;
  logic              dec_reg2loc;
  logic              dec_uncond_br;
  logic              dec_is_bl;
  logic              flush;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [AW-1:0]     ex_aw;
  logic [DATA_W-1:0] ex_alu_out;
  logic              mem_regwrite;
  logic [AW-1:0]     mem_aw;
  logic [DATA_W-1:0] mem_data;
  logic              wb_regwrite;
  logic [AW-1:0]     wb_aw;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              dec_zero;
  logic [DATA_W-1:0] dec_branch_pc;
  logic              id_valid;
  logic [DATA_W-1:0] id_da;
  logic [DATA_W-1:0] id_db;
  logic [AW-1:0]     id_aa;
  logic [AW-1:0]     id_ab;
  logic [AW-1:0]     id_aw;
  logic [DATA_W-1:0] id_imm12;
  logic [DATA_W-1:0] id_daddr9;

  modport slave (
    input  dec_valid, dec_inst, dec_pc, dec_reg2loc, dec_uncond_br, dec_is_bl, flush,
    input  ex_regwrite, ex_memread, ex_aw, ex_alu_out,
    input  mem_regwrite, mem_aw, mem_data,
    input  wb_regwrite, wb_aw, wb_data,
    output stall, dec_zero, dec_branch_pc,
    output id_valid, id_da, id_db, id_aa, id_ab, id_aw, id_imm12, id_daddr9
  );

  modport master (
    output dec_valid, dec_inst, dec_pc, dec_reg2loc, dec_uncond_br, dec_is_bl, flush,
    output ex_regwrite, ex_memread, ex_aw, ex_alu_out,
    output mem_regwrite, mem_aw, mem_data,
    output wb_regwrite, wb_aw, wb_data,
    input  stall, dec_zero, dec_branch_pc,
    input  id_valid, id_da, id_db, id_aa, id_ab, id_aw, id_imm12, id_daddr9
  );
endinterface

// File: rtl/regfile_2r2w.sv
// Architectural register file: two async read ports, WB write port and a BL link port.
module regfile_2r2w #(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  parameter int LINK_REG = 30,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra_a_i,
  input  logic [AW-1:0]     ra_b_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_aw_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lk_we_i,
  input  logic [DATA_W-1:0] lk_data_i
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
  localparam logic [AW-1:0] LR = AW'(LINK_REG);

  logic [DATA_W-1:0] rf_q [NREGS];

  // Link write is issued last so it overrides a WB write to the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (wb_we_i && (wb_aw_i != ZR)) rf_q[wb_aw_i] <= wb_data_i;
      if (lk_we_i) rf_q[LR] <= lk_data_i;
    end
  end

  assign rd_a_o = (ra_a_i == ZR) ? '0 : rf_q[ra_a_i];
  assign rd_b_o = (ra_b_i == ZR) ? '0 : rf_q[ra_b_i];

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode stage: register read with bypass, load-use stall, branch target, ID/EX register.
module decode_regfile_stage
  import decode_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input logic                  clk,
  input logic                  reset,
  decode_regfile_stage_if.slave bus
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [AW-1:0]     aa, ab, aw;
  logic [DATA_W-1:0] rf_a, rf_b, da, db;
  logic [DATA_W-1:0] imm12, daddr9, br_off;
  fwd_sel_e          sel_a, sel_b;
  logic              stall, bubble, link_we;
  logic              unused_inst;

  assign aa = bus.dec_inst[9:5];
  assign aw = bus.dec_inst[4:0];
  assign ab = bus.dec_reg2loc ? bus.dec_inst[4:0] : bus.dec_inst[20:16];
  assign unused_inst = ^bus.dec_inst[31:26];

  assign stall = bus.dec_valid && bus.ex_memread && bus.ex_regwrite && (bus.ex_aw != ZR) &&
                 ((bus.ex_aw == aa) || (bus.ex_aw == ab));
  assign bubble  = stall || bus.flush || !bus.dec_valid;
  assign link_we = bus.dec_valid && bus.dec_is_bl && !stall && !bus.flush;

  regfile_2r2w #(
    .DATA_W(DATA_W), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .LINK_REG(LINK_REG)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .ra_a_i    (aa),
    .ra_b_i    (ab),
    .rd_a_o    (rf_a),
    .rd_b_o    (rf_b),
    .wb_we_i   (bus.wb_regwrite),
    .wb_aw_i   (bus.wb_aw),
    .wb_data_i (bus.wb_data),
    .lk_we_i   (link_we),
    .lk_data_i (bus.dec_pc + DATA_W'(4))
  );

  assign sel_a = fwd_pick(aa == ZR, bus.ex_regwrite && (bus.ex_aw == aa),
                          bus.mem_regwrite && (bus.mem_aw == aa),
                          bus.wb_regwrite && (bus.wb_aw == aa));
  assign sel_b = fwd_pick(ab == ZR, bus.ex_regwrite && (bus.ex_aw == ab),
                          bus.mem_regwrite && (bus.mem_aw == ab),
                          bus.wb_regwrite && (bus.wb_aw == ab));

  always_comb begin
    da = rf_a;
    unique case (sel_a)
      FWD_ZERO: da = '0;
      FWD_EX:   da = bus.ex_alu_out;
      FWD_MEM:  da = bus.mem_data;
      FWD_WB:   da = bus.wb_data;
      default:  da = rf_a;
    endcase
  end

  always_comb begin
    db = rf_b;
    unique case (sel_b)
      FWD_ZERO: db = '0;
      FWD_EX:   db = bus.ex_alu_out;
      FWD_MEM:  db = bus.mem_data;
      FWD_WB:   db = bus.wb_data;
      default:  db = rf_b;
    endcase
  end

  assign imm12  = {{(DATA_W-12){1'b0}}, bus.dec_inst[21:10]};
  assign daddr9 = {{(DATA_W-9){bus.dec_inst[20]}}, bus.dec_inst[20:12]};
  assign br_off = bus.dec_uncond_br ? {{(DATA_W-26){bus.dec_inst[25]}}, bus.dec_inst[25:0]}
                                    : {{(DATA_W-19){bus.dec_inst[23]}}, bus.dec_inst[23:5]};

  assign bus.stall         = stall;
  assign bus.dec_zero      = (db == '0);
  assign bus.dec_branch_pc = bus.dec_pc + (br_off << 2);

  logic              id_valid_q, id_valid_d;
  logic [DATA_W-1:0] id_da_q, id_da_d, id_db_q, id_db_d;
  logic [AW-1:0]     id_aa_q, id_aa_d, id_ab_q, id_ab_d, id_aw_q, id_aw_d;
  logic [DATA_W-1:0] id_imm12_q, id_imm12_d, id_daddr9_q, id_daddr9_d;

  always_comb begin
    id_valid_d  = 1'b0;
    id_da_d     = '0;
    id_db_d     = '0;
    id_aa_d     = '0;
    id_ab_d     = '0;
    id_aw_d     = '0;
    id_imm12_d  = '0;
    id_daddr9_d = '0;
    if (!bubble) begin
      id_valid_d  = 1'b1;
      id_da_d     = da;
      id_db_d     = db;
      id_aa_d     = aa;
      id_ab_d     = ab;
      id_aw_d     = aw;
      id_imm12_d  = imm12;
      id_daddr9_d = daddr9;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_q  <= 1'b0;
      id_da_q     <= '0;
      id_db_q     <= '0;
      id_aa_q     <= '0;
      id_ab_q     <= '0;
      id_aw_q     <= '0;
      id_imm12_q  <= '0;
      id_daddr9_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_da_q     <= id_da_d;
      id_db_q     <= id_db_d;
      id_aa_q     <= id_aa_d;
      id_ab_q     <= id_ab_d;
      id_aw_q     <= id_aw_d;
      id_imm12_q  <= id_imm12_d;
      id_daddr9_q <= id_daddr9_d;
    end
  end

  assign bus.id_valid  = id_valid_q;
  assign bus.id_da     = id_da_q;
  assign bus.id_db     = id_db_q;
  assign bus.id_aa     = id_aa_q;
  assign bus.id_ab     = id_ab_q;
  assign bus.id_aw     = id_aw_q;
  assign bus.id_imm12  = id_imm12_q;
  assign bus.id_daddr9 = id_daddr9_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed bench for decode_regfile_stage: forwarding, load-use, BL link, CBZ, reset.
module tb_decode_regfile_stage;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  decode_regfile_stage_if #(.DATA_W(64), .AW(5)) bus ();

  decode_regfile_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] rb, input logic [4:0] rn,
                                      input logic [4:0] rd);
    return {11'b0, rb, 6'b0, rn, rd};
  endfunction

  task automatic idle();
    bus.dec_valid = 0; bus.dec_inst = '0; bus.dec_pc = '0;
    bus.dec_reg2loc = 0; bus.dec_uncond_br = 0; bus.dec_is_bl = 0; bus.flush = 0;
    bus.ex_regwrite = 0; bus.ex_memread = 0; bus.ex_aw = '0; bus.ex_alu_out = '0;
    bus.mem_regwrite = 0; bus.mem_aw = '0; bus.mem_data = '0;
    bus.wb_regwrite = 0; bus.wb_aw = '0; bus.wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_da", bus.id_da, 64'd0);
    tick();
    reset = 1'b1;

    // WB write X5, then read it back with Ab = X31
    bus.wb_regwrite = 1; bus.wb_aw = 5; bus.wb_data = 64'h1234;
    tick();
    idle();
    bus.dec_valid = 1; bus.dec_inst = ins(5'd31, 5'd5, 5'd1);
    tick();
    chk("x5_valid", 64'(bus.id_valid), 64'd1);
    chk("x5_da", bus.id_da, 64'h1234);
    chk("x31_db", bus.id_db, 64'd0);
    chk("x5_aa", 64'(bus.id_aa), 64'd5);
    chk("x5_ab", 64'(bus.id_ab), 64'd31);
    chk("x5_aw", 64'(bus.id_aw), 64'd1);

    // Forwarding priority on X3
    bus.dec_inst = ins(5'd0, 5'd3, 5'd2);
    bus.ex_regwrite = 1;  bus.ex_aw = 3;  bus.ex_alu_out = 64'hAA;
    bus.mem_regwrite = 1; bus.mem_aw = 3; bus.mem_data = 64'hBB;
    bus.wb_regwrite = 1;  bus.wb_aw = 3;  bus.wb_data = 64'hCC;
    tick();
    chk("fwd_ex", bus.id_da, 64'hAA);
    bus.ex_regwrite = 0;
    tick();
    chk("fwd_mem", bus.id_da, 64'hBB);
    bus.mem_regwrite = 0;
    tick();
    chk("fwd_wb", bus.id_da, 64'hCC);
    bus.wb_regwrite = 0;
    tick();
    chk("rf_x3", bus.id_da, 64'hCC);

    // Load-use on X7
    idle();
    bus.ex_regwrite = 1; bus.ex_memread = 1; bus.ex_aw = 7; bus.ex_alu_out = 64'h999;
    bus.dec_valid = 1; bus.dec_inst = ins(5'd7, 5'd2, 5'd9);
    #1;
    chk("lu_stall", 64'(bus.stall), 64'd1);
    tick();
    chk("lu_bubble", 64'(bus.id_valid), 64'd0);
    chk("lu_bubble_db", bus.id_db, 64'd0);
    bus.ex_regwrite = 0; bus.ex_memread = 0;
    bus.mem_regwrite = 1; bus.mem_aw = 7; bus.mem_data = 64'h7777;
    #1;
    chk("lu_release", 64'(bus.stall), 64'd0);
    tick();
    chk("lu_valid", 64'(bus.id_valid), 64'd1);
    chk("lu_db_mem", bus.id_db, 64'h7777);
    chk("lu_aw", 64'(bus.id_aw), 64'd9);

    // A load into X31 never stalls
    idle();
    bus.ex_regwrite = 1; bus.ex_memread = 1; bus.ex_aw = 31;
    bus.dec_valid = 1; bus.dec_inst = ins(5'd31, 5'd31, 5'd0);
    #1;
    chk("lu_zr_nostall", 64'(bus.stall), 64'd0);

    // BL at 0x100, imm26 = 4, WB to X30 on the same edge
    idle();
    bus.dec_valid = 1; bus.dec_inst = 32'h9400_0004; bus.dec_pc = 64'h100;
    bus.dec_uncond_br = 1; bus.dec_is_bl = 1;
    bus.wb_regwrite = 1; bus.wb_aw = 30; bus.wb_data = 64'h55;
    #1;
    chk("bl_target", bus.dec_branch_pc, 64'h110);
    tick();
    chk("bl_aw", 64'(bus.id_aw), 64'd4);
    idle();
    bus.dec_valid = 1; bus.dec_inst = ins(5'd0, 5'd30, 5'd0);
    tick();
    chk("bl_link", bus.id_da, 64'h104);

    // Flushed BL: bubble and no link write
    idle();
    bus.dec_valid = 1; bus.dec_inst = 32'h9400_0004; bus.dec_pc = 64'h200;
    bus.dec_uncond_br = 1; bus.dec_is_bl = 1; bus.flush = 1;
    tick();
    chk("flush_bubble", 64'(bus.id_valid), 64'd0);
    idle();
    bus.dec_valid = 1; bus.dec_inst = ins(5'd0, 5'd30, 5'd0);
    tick();
    chk("flush_nolink", bus.id_da, 64'h104);

    // Backward unconditional branch wraps modulo 2^64
    idle();
    bus.dec_inst = 32'h97FF_FFFF; bus.dec_uncond_br = 1;
    #1;
    chk("br_wrap", bus.dec_branch_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // CBZ with Db forwarded as 0 from EX, imm19 = -2
    idle();
    bus.dec_valid = 1; bus.dec_pc = 64'h40; bus.dec_reg2loc = 1;
    bus.dec_inst = {8'hB4, 19'h7FFFE, 5'd12};
    bus.ex_regwrite = 1; bus.ex_aw = 12; bus.ex_alu_out = 64'd0;
    #1;
    chk("cbz_zero", 64'(bus.dec_zero), 64'd1);
    chk("cbz_target", bus.dec_branch_pc, 64'h38);
    bus.ex_alu_out = 64'd5;
    #1;
    chk("cbz_nonzero", 64'(bus.dec_zero), 64'd0);

    // Immediate extenders
    idle();
    bus.dec_valid = 1; bus.dec_inst = 32'h003F_FC00;
    tick();
    chk("imm12_max", bus.id_imm12, 64'hFFF);
    chk("daddr9_neg", bus.id_daddr9, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.dec_inst = 32'h0004_0000;
    tick();
    chk("imm12_pos", bus.id_imm12, 64'h100);
    chk("daddr9_pos", bus.id_daddr9, 64'h40);

    // Reset mid-stream
    idle();
    bus.dec_valid = 1; bus.dec_inst = ins(5'd0, 5'd5, 5'd0);
    tick();
    chk("pre_rst_x5", bus.id_da, 64'h1234);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.id_valid), 64'd0);
    chk("mid_rst_da", bus.id_da, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_x5", bus.id_da, 64'd0);
    chk("post_rst_valid", 64'(bus.id_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/decode_regfile_stage.md
# decode_regfile_stage

Parametrised decode stage for the 5-stage pipelined CPU. It contains the architectural register file, in-stage operand forwarding with internal priority select, load-use hazard detection, a dedicated link-register write port for BL, and the ID/EX pipeline register. Branch target and CBZ zero test are resolved combinationally in decode; all operand and immediate outputs to EX are registered.

## Interface
- DATA_W, 64: datapath width.
- NREGS, 32: register count; address width AW = $clog2(NREGS).
- ZERO_REG, 31: index that reads as 0 and ignores writes.
- LINK_REG, 30: target of BL link write.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- dec_valid  in  1  IF/ID holds a valid instruction.
- dec_inst  in  32  instruction word.
- dec_pc  in  DATA_W  instruction PC.
- dec_reg2loc, dec_uncond_br, dec_is_bl  in  1  each; decode controls.
- flush  in  1  squash the instruction currently in decode.
- ex_regwrite, ex_memread  in  1  each; EX-stage controls.
- ex_aw  in  AW  EX-stage destination register.
- ex_alu_out  in  DATA_W  EX-stage result.
- mem_regwrite  in  1  MEM-stage write enable.
- mem_aw  in  AW  MEM-stage destination register.
- mem_data  in  DATA_W  MEM-stage result.
- wb_regwrite  in  1  WB write enable.
- wb_aw  in  AW  WB destination register.
- wb_data  in  DATA_W  WB write data.
- stall  out  1  combinational load-use stall to PC and IF/ID.
- dec_zero  out  1  combinational; forwarded Db == 0.
- dec_branch_pc  out  DATA_W  combinational branch target.
- id_valid  out  1  registered; ID/EX valid.
- id_da, id_db  out  DATA_W  registered operands.
- id_aa, id_ab, id_aw  out  AW  registered register addresses.
- id_imm12, id_daddr9  out  DATA_W  registered extended immediates.

## Operation
- Aa = inst[9:5]; Aw = inst[4:0]; Ab = dec_reg2loc ? inst[4:0] : inst[20:16].
- Operand select, per port, in priority order: address == ZERO_REG -> 0; EX match (ex_regwrite, ex_aw == addr) -> ex_alu_out; MEM match -> mem_data; WB match -> wb_data (write-through bypass); otherwise the register file value.
- Load-use: stall = dec_valid & ex_memread & ex_regwrite & ex_aw != ZERO_REG & (ex_aw == Aa | ex_aw == Ab).
- The register file writes on the rising edge, not the falling edge. Writes to ZERO_REG are dropped.
- Link port: when dec_valid & dec_is_bl & !stall & !flush, write dec_pc + 4 to LINK_REG. If WB targets LINK_REG on the same edge, the link write wins.
- Immediates: imm12 = zero-extend inst[21:10]; daddr9 = sign-extend inst[20:12].
- Branch: off = dec_uncond_br ? sext(inst[25:0]) : sext(inst[23:5]); dec_branch_pc = dec_pc + (off << 2), modulo 2^DATA_W.
- ID/EX register: when stall | flush | !dec_valid, it loads a bubble (id_valid = 0, all data fields 0). Otherwise it captures the decoded values.

## Timing
- Reset asserted: all registers = 0, all id_* outputs = 0, id_valid = 0, regardless of clk.
- Reset is released synchronously into normal operation: the first edge after deassertion is an ordinary update.
- Latency: decode inputs appear on id_* one edge later. stall, dec_zero and dec_branch_pc are valid in the same cycle.
- A stall holds for as long as the hazard persists, which is one cycle for a single load followed by its use.
- Flush and stall asserted together: flush dominates, producing a bubble and no link write.
- Reset mid-operation clears the register file contents and any in-flight ID/EX entry.

## Structure
- Package decode_pkg holds the ZERO_REG/LINK_REG defaults and the fwd_sel_e enum {FWD_REG, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO}.
- Sub-module regfile_2r2w: 2 read ports, WB write port plus link write port with link priority, ZERO_REG handling, async active-low reset.
- Forwarding, hazard logic, extenders and the ID/EX register are all in the top module.

## Test plan
- Reset then write X5 = 0x1234 via WB; next decode reads Aa = 5 -> id_da = 0x1234. Read of X31 -> 0.
- EX writes X3 = 0xAA, MEM writes X3 = 0xBB, WB writes X3 = 0xCC in the same cycle; decode reads X3 -> id_da = 0xAA. Remove EX -> 0xBB. Remove MEM -> 0xCC.
- LDUR to X7 in EX (ex_memread = 1), decode ADD uses X7 -> stall = 1 for 1 cycle, id_valid = 0. After release, the operand comes from MEM forwarding.
- BL at dec_pc = 0x100 with imm26 = 4 -> dec_branch_pc = 0x110, X30 = 0x104. With WB writing X30 = 0x55 on the same edge -> X30 = 0x104.
- CBZ with Db forwarded as 0 from EX and imm19 = -2 at PC 0x40 -> dec_zero = 1, dec_branch_pc = 0x38.
- Assert reset low mid-stream -> id_valid = 0 and all outputs 0 immediately. X5 then reads 0.
